// File: rtl/ram_io_responder_pkg.sv
// Shared decode constants and helpers for the RAM / memory-mapped I/O responder.
package ram_io_responder_pkg;

  localparam logic [1:0]  IO_BASE      = 2'b11;
  localparam logic [31:0] IO_DATA_ADDR = 32'h0003_0000;
  localparam logic [31:0] IO_STAT_ADDR = 32'h0003_0004;

  localparam int unsigned STAT_RX_NONEMPTY_BIT = 0;
  localparam int unsigned STAT_TX_FULL_BIT     = 1;

  typedef enum logic [1:0] {
    AccRam,
    AccIoData,
    AccIoStat,
    AccIoOther
  } access_e;

  function automatic access_e decode_addr(input logic [31:0] addr);
    if (addr[17:16] != IO_BASE) return AccRam;
    if (addr == IO_DATA_ADDR)   return AccIoData;
    if (addr == IO_STAT_ADDR)   return AccIoStat;
    return AccIoOther;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Show-ahead byte FIFO; a push into a full FIFO is taken when a pop happens in the same cycle.
module byte_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             din,
  output logic [7:0]             dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [7:0]      r_mem [DEPTH];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_count;
  logic            w_push;
  logic            w_pop;

  assign full   = (r_count == CntW'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);
  // Gate the head so stale storage never shows while empty (e.g. right after reset).
  assign dout   = empty ? 8'h00 : r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/ram_io_responder.sv
// Byte-serial RAM port target: on-chip byte RAM plus an I/O window with UART TX/RX FIFOs,
// a status byte and a sticky halt register.
module ram_io_responder
  import ram_io_responder_pkg::*;
#(
  parameter int unsigned RAM_ADDR_BITS = 17,
  parameter int unsigned TX_DEPTH      = 8,
  parameter int unsigned RX_DEPTH      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_rw,
  input  logic [31:0] addr_in,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        if_uart_full,
  output logic        halt,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready
);

  localparam int unsigned TxCntW = $clog2(TX_DEPTH) + 1;
  localparam int unsigned RxCntW = $clog2(RX_DEPTH) + 1;
  // One slot of margin: the controller commits to a write after sampling this flag.
  localparam logic [TxCntW-1:0] TxFullLvl = TxCntW'(TX_DEPTH - 1);

  logic [7:0]              r_mem [0:(1 << RAM_ADDR_BITS) - 1];
  logic [7:0]              r_data_out;
  logic                    r_halt;
  logic                    r_tx_drop;

  logic [RAM_ADDR_BITS-1:0] w_ram_idx;
  logic [7:0]               w_rd_data;
  logic [7:0]               w_stat;
  logic                     w_ram_we;
  logic                     w_halt_set;
  logic                     w_tx_push;
  logic                     w_tx_pop;
  logic                     w_tx_full;
  logic                     w_tx_empty;
  logic [TxCntW-1:0]        w_tx_count;
  logic                     w_tx_drop_evt;
  logic                     w_rx_push;
  logic                     w_rx_pop;
  logic                     w_rx_full;
  logic                     w_rx_empty;
  logic [RxCntW-1:0]        w_rx_count;
  logic [7:0]               w_rx_head;

  assign w_ram_idx     = addr_in[RAM_ADDR_BITS-1:0];
  assign w_tx_pop      = !w_tx_empty && tx_ready;
  assign w_tx_drop_evt = w_tx_push && w_tx_full && !w_tx_pop;
  assign w_rx_push     = rx_valid && !w_rx_full;

  assign data_out     = r_data_out;
  assign halt         = r_halt;
  assign tx_valid     = !w_tx_empty;
  assign if_uart_full = (w_tx_count >= TxFullLvl);
  assign rx_ready     = (w_rx_count != RxCntW'(RX_DEPTH));

  always_comb begin
    w_stat                       = '0;
    w_stat[STAT_TX_FULL_BIT]     = w_tx_full;
    w_stat[STAT_RX_NONEMPTY_BIT] = !w_rx_empty;
  end

  always_comb begin
    w_rd_data  = r_data_out;
    w_ram_we   = 1'b0;
    w_halt_set = 1'b0;
    w_tx_push  = 1'b0;
    w_rx_pop   = 1'b0;
    if (rdy) begin
      case (decode_addr(addr_in))
        AccRam: begin
          if (if_rw) w_ram_we  = 1'b1;
          else       w_rd_data = r_mem[w_ram_idx];
        end
        AccIoData: begin
          if (if_rw) begin
            w_tx_push = 1'b1;
          end else if (!w_rx_empty) begin
            w_rd_data = w_rx_head;
            w_rx_pop  = 1'b1;
          end else begin
            w_rd_data = 8'h00;
          end
        end
        AccIoStat: begin
          if (if_rw) w_halt_set = 1'b1;
          else       w_rd_data  = w_stat;
        end
        default: begin
          if (!if_rw) w_rd_data = 8'h00;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_ram_we) r_mem[w_ram_idx] <= data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_out <= 8'h00;
      r_halt     <= 1'b0;
      r_tx_drop  <= 1'b0;
    end else begin
      r_data_out <= w_rd_data;
      r_halt     <= r_halt | w_halt_set;
      r_tx_drop  <= r_tx_drop | w_tx_drop_evt;
    end
  end

  byte_fifo #(
    .DEPTH(TX_DEPTH)
  ) u_tx_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (w_tx_push),
    .pop  (w_tx_pop),
    .din  (data_in),
    .dout (tx_data),
    .full (w_tx_full),
    .empty(w_tx_empty),
    .count(w_tx_count)
  );

  byte_fifo #(
    .DEPTH(RX_DEPTH)
  ) u_rx_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (w_rx_push),
    .pop  (w_rx_pop),
    .din  (rx_data),
    .dout (w_rx_head),
    .full (w_rx_full),
    .empty(w_rx_empty),
    .count(w_rx_count)
  );

endmodule

// File: doc/ram_io_responder.md
# ram_io_responder

Target-side counterpart of the CPU memory controller's byte-serial RAM port. It accepts one byte access per enabled cycle and serves it from one of two places: an on-chip byte RAM, or a memory-mapped I/O window. The I/O window holds a UART transmit FIFO, a receive FIFO, a status byte and a halt register. It drives `if_uart_full` back to the controller and connects to an external byte sink and byte source through valid/ready handshakes.

## Interface
Parameters:
- `RAM_ADDR_BITS`, 17, byte RAM is 2^17 = 128 KiB, indexed by `addr_in[16:0]`
- `TX_DEPTH`, 8, transmit FIFO entries (power of two)
- `RX_DEPTH`, 8, receive FIFO entries (power of two)

Ports:
- `clk` in 1: single clock, all state on posedge
- `rst` in 1: asynchronous, active-high reset
- `rdy` in 1: CPU-side access enable; external handshakes ignore it
- `if_rw` in 1: 0 = read, 1 = write
- `addr_in` in 32: byte address
- `data_in` in 8: write byte
- `data_out` out 8: read byte, registered
- `if_uart_full` out 1: TX FIFO has at most one free entry
- `halt` out 1: sticky program-end flag
- `tx_valid` out 1, `tx_data` out 8, `tx_ready` in 1: UART sink handshake
- `rx_valid` in 1, `rx_data` in 8, `rx_ready` out 1: input source handshake

## Operation
- Address decode:
  - I/O when `addr_in[17:16] == 2'b11`, otherwise RAM.
  - I/O registers: `IO_DATA` = 0x30000, `IO_STAT` = 0x30004. Other I/O addresses read 0x00 and ignore writes.
- RAM write: `mem[addr_in[16:0]] <= data_in`. RAM read: `data_out <= mem[addr_in[16:0]]`.
- `IO_DATA` write: push `data_in` into the TX FIFO. If the FIFO is full and not popping this cycle, the byte is dropped and `tx_drop` is set (sticky internal flag).
- `IO_DATA` read:
  - RX non-empty: `data_out <= rx head` and pop.
  - RX empty: `data_out <= 0x00`, no pop.
- `IO_STAT` read: `data_out <= {6'b0, tx_full, rx_nonempty}`.
- `IO_STAT` write of any value: `halt <= 1`, which holds until reset.
- `rdy == 0`: no RAM or I/O access, `data_out` holds, `halt` holds. FIFO drain and fill still proceed.
- TX side:
  - `tx_valid = tx_count != 0`, `tx_data = tx head` (show-ahead).
  - Pop when `tx_valid && tx_ready`.
  - Push into a full FIFO is accepted in the same cycle as a pop.
- RX side:
  - `rx_ready = rx_count != RX_DEPTH`.
  - Push when `rx_valid && rx_ready`.
  - A CPU pop and an external push in the same cycle leave the count unchanged.
- `if_uart_full = tx_count >= TX_DEPTH-1`. The controller checks it before starting a write and relies on one slot of margin.
- FIFO pointers are `log2(DEPTH)` bits and wrap modulo DEPTH. Counts are `log2(DEPTH)+1` bits.
- Reset values:
  - `data_out` = 0, `if_uart_full` = 0, `halt` = 0, `tx_valid` = 0, `tx_data` = 0, `rx_ready` = 1.
  - FIFO pointers and counts = 0, `tx_drop` = 0.
  - RAM contents are not reset; simulation preloads them with `$readmemh`.

## Timing
- Read latency is 1 cycle: the address and `if_rw=0` presented in cycle t produce `data_out` valid in cycle t+1 and held until the next enabled read. This matches the controller capturing at stage 2.
- Consecutive-address reads return one byte per cycle, so a 4-byte fetch completes in 4 cycles after the first address.
- Write effects:
  - A RAM write in cycle t is visible to a read in cycle t+1.
  - A TX push in cycle t gives `tx_valid=1` at t+1 at the earliest.
  - `if_uart_full` updates in the same edge as the count.
- RX push in cycle t: the byte is readable via `IO_DATA` from cycle t+1.
- `rst` asserted mid-transfer: outputs go to reset values immediately (asynchronous). In-flight FIFO contents are discarded.

## Structure
- Shared package: `IO_BASE` (2'b11 decode), `IO_DATA_ADDR` = 32'h30000, `IO_STAT_ADDR` = 32'h30004, and the status bit indices.
- Sub-module `byte_fifo` (parameter `DEPTH`, show-ahead, push/pop/full/empty/count, asynchronous reset), instantiated once for TX and once for RX.
- The top level holds the RAM array, the decode logic, the `data_out` register and the halt register.

## Test plan
- Write 0xA5 at 0x00010, read 0x00010 -> `data_out` = 0xA5 exactly one cycle after the read address.
- Write bytes 0x13, 0x05, 0x00, 0x00 to 0x100–0x103, then read them back-to-back -> 0x13, 0x05, 0x00, 0x00 on four consecutive cycles.
- With `tx_ready=0`, write 7 bytes to 0x30000 -> `if_uart_full` rises after the 7th push. After an 8th push, a 9th push is dropped. Raise `tx_ready` -> the 8 bytes drain in order, one per cycle.
- Drive `rx_data` 0x41 then 0x42 -> reading 0x30004 returns 0x01, reading 0x30000 twice returns 0x41 then 0x42, and a third read returns 0x00.
- Write to 0x30004 -> `halt`=1 next cycle. Pulse `rst` asynchronously between edges -> `halt`, `tx_valid`, `data_out` go to 0 and `rx_ready` goes to 1 before the next edge.
- Hold `rdy=0` while presenting a RAM write -> memory unchanged, while a pending TX byte still drains.
